// File: rtl/delay_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : delay_buffer_ctrl_if
// Purpose  : Configuration, stream and buffer-side signals of delay_buffer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface delay_buffer_ctrl_if #(
    parameter int MAX_DELAY = 128
);
    localparam int DW = $clog2(MAX_DELAY);

    logic          cfg_valid;
    logic [DW-1:0] cfg_delay;
    logic          cfg_ready;
    logic          s_valid;
    logic          s_ready;
    logic          buf_valid_in;
    logic [DW-1:0] buf_delay;
    logic          buf_flush;
    logic          buf_valid_out;
    logic          primed;
    logic [DW:0]   fill_cnt;
    logic          err;

    // Environment side: requester, stream source and the delay buffer itself
    modport master (
        output cfg_valid,
        output cfg_delay,
        output s_valid,
        output buf_valid_out,
        input  cfg_ready,
        input  s_ready,
        input  buf_valid_in,
        input  buf_delay,
        input  buf_flush,
        input  primed,
        input  fill_cnt,
        input  err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_delay,
        input  s_valid,
        input  buf_valid_out,
        output cfg_ready,
        output s_ready,
        output buf_valid_in,
        output buf_delay,
        output buf_flush,
        output primed,
        output fill_cnt,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/delay_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : delay_buffer_ctrl
// Purpose  : Sequences delay reconfiguration of a ping-pong delay buffer:
//            stall, drain, flush, refill, then run.
// Revision : 1.0 - initial release
// ============================================================================
module delay_buffer_ctrl #(
    parameter int MAX_DELAY    = 128,
    parameter int DRAIN_CYCLES = 3
) (
    input  wire                clk,
    input  wire                rst,
    delay_buffer_ctrl_if.slave bus
);

    localparam int DW  = $clog2(MAX_DELAY);
    localparam int CW  = DW + 1;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_FILL  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0]  FILL_MAX   = '1;
    localparam logic [CW-1:0]  FILL_SLACK = CW'(4);
    localparam logic [DW-1:0]  MIN_DELAY  = DW'(2);

    logic [2:0]     state_q,      state_d;
    logic [DW-1:0]  pend_delay_q, pend_delay_d;
    logic [DCW-1:0] drain_cnt_q,  drain_cnt_d;
    logic [CW-1:0]  fill_cnt_q,   fill_cnt_d;
    logic [DW-1:0]  buf_delay_q,  buf_delay_d;
    logic           err_q,        err_d;

    logic           w_cfg_ready;
    logic           w_s_ready;
    logic           w_primed;
    logic           w_flush;
    logic           w_cfg_hs;
    logic           w_wr;
    logic [DW-1:0]  w_clamped;
    logic [CW-1:0]  w_err_limit;

    // Handshake-facing outputs depend on state only
    always_comb begin
        w_cfg_ready = 1'b0;
        w_s_ready   = 1'b0;
        w_primed    = 1'b0;
        w_flush     = 1'b0;
        case (state_q)
            ST_IDLE:  w_cfg_ready = 1'b1;
            ST_FLUSH: w_flush     = 1'b1;
            ST_FILL:  w_s_ready   = 1'b1;
            ST_RUN: begin
                w_cfg_ready = 1'b1;
                w_s_ready   = 1'b1;
                w_primed    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_cfg_hs    = bus.cfg_valid & w_cfg_ready;
    assign w_wr        = bus.s_valid & w_s_ready;
    assign w_clamped   = (bus.cfg_delay < MIN_DELAY) ? MIN_DELAY : bus.cfg_delay;
    assign w_err_limit = {1'b0, buf_delay_q} + FILL_SLACK;

    always_comb begin
        state_d      = state_q;
        pend_delay_d = pend_delay_q;
        drain_cnt_d  = drain_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        buf_delay_d  = buf_delay_q;
        err_d        = err_q;

        if (w_wr && (fill_cnt_q != FILL_MAX)) begin
            fill_cnt_d = fill_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Nothing has been written yet, so there is nothing to drain
                if (w_cfg_hs) begin
                    pend_delay_d = w_clamped;
                    state_d      = ST_FLUSH;
                end
            end
            ST_RUN: begin
                if (w_cfg_hs) begin
                    pend_delay_d = w_clamped;
                    drain_cnt_d  = '0;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_FLUSH;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            ST_FLUSH: begin
                buf_delay_d = pend_delay_q;
                fill_cnt_d  = '0;
                err_d       = 1'b0;
                state_d     = ST_FILL;
            end
            ST_FILL: begin
                if (bus.buf_valid_out) begin
                    state_d = ST_RUN;
                end else if (fill_cnt_q >= w_err_limit) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_delay_q <= '0;
            drain_cnt_q  <= '0;
            fill_cnt_q   <= '0;
            buf_delay_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_delay_q <= pend_delay_d;
            drain_cnt_q  <= drain_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            buf_delay_q  <= buf_delay_d;
            err_q        <= err_d;
        end
    end

    assign bus.cfg_ready    = w_cfg_ready;
    assign bus.s_ready      = w_s_ready;
    assign bus.buf_valid_in = w_wr;
    assign bus.buf_delay    = buf_delay_q;
    assign bus.buf_flush    = w_flush;
    assign bus.primed       = w_primed;
    assign bus.fill_cnt     = fill_cnt_q;
    assign bus.err          = err_q;

endmodule
`default_nettype wire

// File: doc/delay_buffer_ctrl.md
# delay_buffer_ctrl

Sequencing controller for the ping-pong `delay_buffer`. It accepts delay reconfiguration requests over a valid/ready handshake and stalls the upstream stream. It then drains in-flight buffer outputs, pulses a flush to the buffer, applies the new delay, and gates samples into the buffer until the first delayed output emerges. Sits between the stream source, the configuration register bank and one `delay_buffer` instance.

## Interface
- `MAX_DELAY`, 128: maximum delay of the controlled buffer; power of two, ≥ 4.
- `DW`: `$clog2(MAX_DELAY)`, derived, not overridable.
- `DRAIN_CYCLES`, 3: cycles waited after input stall before flush; covers buffer read-to-output latency (≤ 2).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: new delay request.
- `cfg_delay` in DW: requested delay in samples.
- `cfg_ready` out 1: request accepted when `cfg_valid & cfg_ready`.
- `s_valid` in 1: upstream sample valid.
- `s_ready` out 1: controller accepts upstream samples.
- `buf_valid_in` out 1: write strobe to buffer, `s_valid & s_ready` (combinational).
- `buf_delay` out DW: delay presented to buffer, registered.
- `buf_flush` out 1: one-cycle pointer/pipeline clear to buffer.
- `buf_valid_out` in 1: buffer output valid.
- `primed` out 1: buffer in steady state, output stream aligned to `buf_delay`.
- `fill_cnt` out DW+1: samples written since last flush, saturating at 2^(DW+1)-1.
- `err` out 1: sticky fill timeout.

## Operation
- States: IDLE, DRAIN, FLUSH, FILL, RUN. Registered `state`, `pend_delay` (DW), `drain_cnt`, `fill_cnt`, `buf_delay`, `err`.
- Delay clamp: `cfg_delay < 2` is stored as 2; all other values unchanged.
- IDLE: `cfg_ready=1`, `s_ready=0`. On handshake, latch `pend_delay` and go to FLUSH. No drain is needed because nothing has been written.
- RUN: `cfg_ready=1`, `s_ready=1`, `primed=1`. On handshake, latch `pend_delay` and go to DRAIN.
  - A sample presented in the handshake cycle is still accepted.
- DRAIN: `s_ready=0`, `cfg_ready=0`. `drain_cnt` counts 0..DRAIN_CYCLES-1, then go to FLUSH.
  - `buf_delay` is held at its old value, so the buffer's output pipeline select does not change mid-drain.
- FLUSH: exactly one cycle.
  - `buf_flush=1`, `s_ready=0`, `cfg_ready=0`.
  - `buf_delay <= pend_delay`, `fill_cnt <= 0`, `err <= 0`.
  - Next state is FILL.
- FILL: `s_ready=1`, `cfg_ready=0`, `primed=0`.
  - `fill_cnt` increments on each `buf_valid_in`.
  - Go to RUN on the first cycle `buf_valid_out=1`.
  - If `fill_cnt` reaches `buf_delay + 4` with no `buf_valid_out`, set `err=1` and remain in FILL.
- `fill_cnt` keeps counting in RUN (saturating); it is informational only.
- `cfg_valid` arriving in DRAIN/FLUSH/FILL is not accepted; the requester holds it until `cfg_ready`.
- `err` clears only on reset or in FLUSH.

## Timing
- Reset values:
  - `state=IDLE`.
  - `cfg_ready=1`.
  - `s_ready=0`, `buf_valid_in=0`, `buf_flush=0`, `primed=0`, `err=0`.
  - `buf_delay=0`, `fill_cnt=0`.
- Reset mid-operation returns to IDLE on the next edge and discards `pend_delay`. The buffer is reset separately.
- Handshake in RUN at cycle T:
  - DRAIN occupies T+1..T+DRAIN_CYCLES.
  - FLUSH at T+DRAIN_CYCLES+1, with `buf_delay` updated at the end of that cycle.
  - FILL from T+DRAIN_CYCLES+2.
- Handshake in IDLE at T: FLUSH at T+1, FILL from T+2.
- `s_ready` and `cfg_ready` are Moore outputs (decoded from state only).
- `buf_valid_out` in the same cycle as the RUN→DRAIN handshake is ignored by the controller.
- `primed` rises in the cycle after the first `buf_valid_out` seen in FILL.

## Test plan
- Reset, then `cfg_delay=8` in IDLE → FLUSH pulse at T+1, `buf_delay=8` from T+2, `s_ready=1` from T+2; with continuous `s_valid`, `primed` rises one cycle after the first `buf_valid_out`; `fill_cnt` is then ≈ 8.
- In RUN with continuous input, request `cfg_delay=5` → `s_ready` low for 4 cycles (3 DRAIN + FLUSH), `buf_delay` unchanged until FLUSH, `buf_flush` high for exactly 1 cycle, `primed` low until refill.
- `cfg_delay=0` and `cfg_delay=1` → `buf_delay=2` after FLUSH.
- `cfg_valid` held high during DRAIN/FILL → `cfg_ready=0` and no second latch; the request is accepted in the first RUN cycle, starting a new DRAIN.
- `buf_valid_out` tied low during FILL with `buf_delay=8` → `err=1` once `fill_cnt=12`; state stays FILL; the next reset clears `err`.
- Assert `rst` during DRAIN and during FILL → next cycle IDLE, all outputs at reset values, no FLUSH pulse.
